exc_irq_ctrl: RTL and testbench

Multi-channel exception/interrupt controller for the LEGv8 core, replacing the single-IRQ combinational exception logic in the controller path. It takes NUM_IRQ external interrupt lines and the decoder's invalid-opcode flag. It latches and masks requests, arbitrates by fixed priority, and runs a request/acknowledge/return handshake with the core. It drives Exc/EStatus to the exception PC logic and ExtIAck back to the interrupt sources.

---
 rtl/exc_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/exc_irq_ctrl.sv | 110 +++++++++++
 tb/tb_exc_irq_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared cause codes and FSM state type for the exception/interrupt controller.
package exc_pkg;

    localparam logic [3:0] ESTAT_NONE  = 4'b0000;
    localparam logic [3:0] ESTAT_IRQ   = 4'b0001;
    localparam logic [3:0] ESTAT_INVOP = 4'b0010;
    localparam logic [3:0] ESTAT_DBLF  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC
    } exc_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downwards so the lowest requesting index is the last assignment.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Multi-channel exception/interrupt controller: latches and masks IRQs, arbitrates
// by fixed priority and runs the request/ack/return handshake with the core.
module exc_irq_ctrl
    import exc_pkg::*;
#(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE  = '0,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = '1,
    parameter int                 ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ExtIRQ,
    input  logic               NotAnInstr,
    input  logic               ExcAck,
    input  logic               ERet,
    input  logic               MaskWe,
    input  logic [NUM_IRQ-1:0] MaskWdata,
    output logic               Exc,
    output logic [3:0]         EStatus,
    output logic [ID_W-1:0]    EIrqId,
    output logic [NUM_IRQ-1:0] ExtIAck,
    output logic               DoubleFault,
    output logic [NUM_IRQ-1:0] IrqMask
);

    exc_state_t         state, state_nx;
    logic [NUM_IRQ-1:0] pending, prev, irq_set, req_vec, ack_c;
    logic [ID_W-1:0]    win_id;
    logic               any_req, exc_c, dblf_set;
    logic [3:0]         estat_c;

    // Edge channels need a rising transition; level channels capture while high.
    assign irq_set = ExtIRQ & (~EDGE_MODE | ~prev);
    assign req_vec = pending & IrqMask;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (req_vec),
        .valid (any_req),
        .id    (win_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            prev        <= '0;
            IrqMask     <= MASK_RESET;
            EIrqId      <= '0;
            DoubleFault <= 1'b0;
        end else begin
            state   <= state_nx;
            prev    <= ExtIRQ;
            pending <= (pending & ~ExtIAck) | irq_set;
            if (MaskWe) IrqMask <= MaskWdata;
            if (state == IDLE && state_nx == REQ) EIrqId <= win_id;
            if (dblf_set) DoubleFault <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        exc_c    = 1'b0;
        estat_c  = ESTAT_NONE;
        ack_c    = '0;
        dblf_set = 1'b0;
        case (state)
            IDLE: begin
                if (NotAnInstr) begin
                    exc_c   = 1'b1;
                    estat_c = ESTAT_INVOP;
                    if (ExcAck) state_nx = SVC;
                end else if (any_req) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                exc_c = 1'b1;
                // An invalid opcode preempts the IRQ, which stays pending for later.
                if (NotAnInstr) begin
                    estat_c = ESTAT_INVOP;
                    if (ExcAck) state_nx = SVC;
                end else begin
                    estat_c = ESTAT_IRQ;
                    if (ExcAck) begin
                        ack_c[EIrqId] = 1'b1;
                        state_nx      = SVC;
                    end
                end
            end
            SVC: begin
                if (NotAnInstr) begin
                    exc_c    = 1'b1;
                    estat_c  = ESTAT_DBLF;
                    dblf_set = 1'b1;
                end
                if (ERet) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign Exc     = reset & exc_c;
    assign EStatus = reset ? estat_c : ESTAT_NONE;
    assign ExtIAck = reset ? ack_c : '0;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl: all channels edge-triggered, mask enabled at reset.
module tb_exc_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ExtIRQ;
    logic       NotAnInstr, ExcAck, ERet, MaskWe;
    logic [3:0] MaskWdata;
    logic       Exc;
    logic [3:0] EStatus;
    logic [1:0] EIrqId;
    logic [3:0] ExtIAck;
    logic       DoubleFault;
    logic [3:0] IrqMask;

    int vectors    = 0;
    int miscompares = 0;

    exc_irq_ctrl #(
        .NUM_IRQ    (4),
        .EDGE_MODE  (4'b1111),
        .MASK_RESET (4'b1111)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ExtIRQ      (ExtIRQ),
        .NotAnInstr  (NotAnInstr),
        .ExcAck      (ExcAck),
        .ERet        (ERet),
        .MaskWe      (MaskWe),
        .MaskWdata   (MaskWdata),
        .Exc         (Exc),
        .EStatus     (EStatus),
        .EIrqId      (EIrqId),
        .ExtIAck     (ExtIAck),
        .DoubleFault (DoubleFault),
        .IrqMask     (IrqMask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; ExtIRQ = '0; NotAnInstr = 1'b1; ExcAck = 1'b0;
        ERet = 1'b0; MaskWe = 1'b0; MaskWdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exc", 32'(Exc), 32'd0);
        chk("rst_estat", 32'(EStatus), 32'd0);
        chk("rst_mask", 32'(IrqMask), 32'hF);
        chk("rst_id", 32'(EIrqId), 32'd0);
        chk("rst_dblf", 32'(DoubleFault), 32'd0);
        NotAnInstr = 1'b0;
        reset = 1'b1;

        // Single edge on channel 2
        tick(); ExtIRQ = 4'b0100;
        tick(); ExtIRQ = 4'b0000;
        chk("t1_no_exc_yet", 32'(Exc), 32'd0);
        chk("t1_pending", 32'(dut.pending), 32'h4);
        tick();
        chk("t1_exc", 32'(Exc), 32'd1);
        chk("t1_estat", 32'(EStatus), 32'd1);
        chk("t1_id", 32'(EIrqId), 32'd2);
        ExcAck = 1'b1; #1;
        chk("t1_iack", 32'(ExtIAck), 32'h4);
        tick(); ExcAck = 1'b0; #1;
        chk("t1_svc_exc", 32'(Exc), 32'd0);
        chk("t1_svc_iack", 32'(ExtIAck), 32'd0);
        chk("t1_pend_clr", 32'(dut.pending), 32'd0);
        ERet = 1'b1;
        tick(); ERet = 1'b0;
        tick();
        chk("t1_idle_exc", 32'(Exc), 32'd0);

        // Two channels pending: 1 before 3
        ExtIRQ = 4'b1010;
        tick(); ExtIRQ = 4'b0000;
        tick();
        chk("t2_exc", 32'(Exc), 32'd1);
        chk("t2_id1", 32'(EIrqId), 32'd1);
        ExcAck = 1'b1; #1;
        chk("t2_iack1", 32'(ExtIAck), 32'h2);
        tick(); ExcAck = 1'b0; ERet = 1'b1;
        tick(); ERet = 1'b0;
        chk("t2_idle", 32'(Exc), 32'd0);
        tick();
        chk("t2_exc3", 32'(Exc), 32'd1);
        chk("t2_id3", 32'(EIrqId), 32'd3);
        chk("t2_estat3", 32'(EStatus), 32'd1);
        ExcAck = 1'b1; #1;
        chk("t2_iack3", 32'(ExtIAck), 32'h8);
        tick(); ExcAck = 1'b0; ERet = 1'b1;
        tick(); ERet = 1'b0;

        // Masked channel 1 held off until re-enabled
        MaskWe = 1'b1; MaskWdata = 4'b1101;
        tick(); MaskWe = 1'b0;
        chk("t3_mask", 32'(IrqMask), 32'hD);
        ExtIRQ = 4'b0010;
        tick(); ExtIRQ = 4'b0000;
        tick();
        chk("t3_masked_a", 32'(Exc), 32'd0);
        tick();
        chk("t3_masked_b", 32'(Exc), 32'd0);
        MaskWe = 1'b1; MaskWdata = 4'b1111;
        tick(); MaskWe = 1'b0;
        tick();
        chk("t3_unmask_exc", 32'(Exc), 32'd1);
        chk("t3_unmask_id", 32'(EIrqId), 32'd1);
        ExcAck = 1'b1;
        tick(); ExcAck = 1'b0; ERet = 1'b1;
        tick(); ERet = 1'b0;

        // Invalid opcode preempts a requested IRQ0
        ExtIRQ = 4'b0001;
        tick(); ExtIRQ = 4'b0000;
        tick();
        chk("t4_req_estat", 32'(EStatus), 32'd1);
        NotAnInstr = 1'b1; #1;
        chk("t4_invop_exc", 32'(Exc), 32'd1);
        chk("t4_invop_estat", 32'(EStatus), 32'd2);
        ExcAck = 1'b1; #1;
        chk("t4_no_iack", 32'(ExtIAck), 32'd0);
        tick(); NotAnInstr = 1'b0; ExcAck = 1'b0; #1;
        chk("t4_still_pend", 32'(dut.pending), 32'h1);
        chk("t4_svc_exc", 32'(Exc), 32'd0);
        chk("t4_no_dblf", 32'(DoubleFault), 32'd0);
        ERet = 1'b1;
        tick(); ERet = 1'b0;
        tick();
        chk("t4_rereq_exc", 32'(Exc), 32'd1);
        chk("t4_rereq_id", 32'(EIrqId), 32'd0);
        chk("t4_rereq_estat", 32'(EStatus), 32'd1);
        ExcAck = 1'b1; #1;
        chk("t4_iack0", 32'(ExtIAck), 32'h1);
        tick(); ExcAck = 1'b0; #1;

        // Double fault inside the handler
        NotAnInstr = 1'b1; #1;
        chk("t5_exc", 32'(Exc), 32'd1);
        chk("t5_estat", 32'(EStatus), 32'd4);
        tick(); NotAnInstr = 1'b0; #1;
        chk("t5_dblf", 32'(DoubleFault), 32'd1);
        chk("t5_exc_off", 32'(Exc), 32'd0);
        ERet = 1'b1;
        tick(); ERet = 1'b0;
        tick();
        chk("t5_dblf_held", 32'(DoubleFault), 32'd1);
        chk("t5_idle_exc", 32'(Exc), 32'd0);

        // Invalid opcode from IDLE: zero latency
        NotAnInstr = 1'b1; #1;
        chk("t6_exc", 32'(Exc), 32'd1);
        chk("t6_estat", 32'(EStatus), 32'd2);
        ExcAck = 1'b1;
        tick(); NotAnInstr = 1'b0; ExcAck = 1'b0; #1;
        chk("t6_svc_exc", 32'(Exc), 32'd0);
        ERet = 1'b1;
        tick(); ERet = 1'b0;

        // Asynchronous reset in the middle of REQ
        MaskWe = 1'b1; MaskWdata = 4'b0011;
        tick(); MaskWe = 1'b0;
        ExtIRQ = 4'b0001;
        tick(); ExtIRQ = 4'b0000;
        tick();
        chk("t7_req", 32'(Exc), 32'd1);
        ExcAck = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("t7_exc", 32'(Exc), 32'd0);
        chk("t7_iack", 32'(ExtIAck), 32'd0);
        chk("t7_pend", 32'(dut.pending), 32'd0);
        chk("t7_mask", 32'(IrqMask), 32'hF);
        chk("t7_dblf", 32'(DoubleFault), 32'd0);
        ExcAck = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
